// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the word-serial adder controller:
//   - state_t            : controller state encoding (2 bits)
//   - DEFAULT_WORDS      : default number of words per operand
//   - DEFAULT_BIT_WIDTH  : default width of one adder slice / word
// No ports (package).
// -----------------------------------------------------------------------------
package adder_seq_pkg;

  localparam int DEFAULT_WORDS     = 4;
  localparam int DEFAULT_BIT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : adder_seq_pkg

// File: rtl/adder_nbit.sv
// -----------------------------------------------------------------------------
// adder_nbit
// Purely combinational BIT_WIDTH-bit adder slice with carry in and carry out.
// Ports:
//   a    [BIT_WIDTH-1:0]  input  : addend word
//   b    [BIT_WIDTH-1:0]  input  : addend word
//   cin                   input  : carry into bit 0
//   sum  [BIT_WIDTH-1:0]  output : a + b + cin, modulo 2^BIT_WIDTH
//   cout                  output : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout
);

  // One extra bit of headroom carries the top-bit carry out.
  logic [BIT_WIDTH:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};
  assign sum     = total_s[BIT_WIDTH-1:0];
  assign cout    = total_s[BIT_WIDTH];

endmodule : adder_nbit

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
// Adds two WORDS*BIT_WIDTH-bit operands using a single BIT_WIDTH-bit adder
// slice, one word per clock, least-significant word first. The carry between
// words is held in a register, so an operation takes WORDS ADD cycles plus one
// DONE cycle.
// Ports:
//   clk       input                  : clock, rising edge
//   rst       input                  : synchronous active-high reset
//   start     input                  : request, only looked at in IDLE
//   op_a      input  [WORDS*BW-1:0]  : operand A, captured on accepted start
//   op_b      input  [WORDS*BW-1:0]  : operand B, captured on accepted start
//   carry_in  input                  : initial carry, captured on accepted start
//   busy      output                 : high in ADD and DONE
//   done      output                 : one-cycle pulse, result valid
//   sum       output [WORDS*BW-1:0]  : registered result
//   overflow  output                 : carry out of the most-significant word
// -----------------------------------------------------------------------------
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int WORDS     = DEFAULT_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORDS*BIT_WIDTH-1:0] op_a,
  input  logic [WORDS*BIT_WIDTH-1:0] op_b,
  input  logic                       carry_in,
  output logic                       busy,
  output logic                       done,
  output logic [WORDS*BIT_WIDTH-1:0] sum,
  output logic                       overflow
);

  // Index counter is one bit wider than strictly needed; the word select
  // below uses only the low bits, which cover 0..WORDS-1.
  localparam int IDX_W = $clog2(WORDS) + 1;
  localparam int SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);

  typedef logic [WORDS-1:0][BIT_WIDTH-1:0] word_vec_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t               state_r;
  state_t               state_next_s;

  word_vec_t            op_a_r;
  word_vec_t            op_b_r;
  word_vec_t            sum_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 carry_r;
  logic                 overflow_r;
  logic                 busy_r;
  logic                 done_r;

  // ---------------------------------------------------------------------------
  // Control strobes decoded from the current state
  // ---------------------------------------------------------------------------
  logic                 accept_s;   // start taken this cycle
  logic                 step_s;     // one word added this cycle
  logic                 last_s;     // current word is the most-significant

  // ---------------------------------------------------------------------------
  // Adder slice connections
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]     idx_sel_s;
  logic [BIT_WIDTH-1:0] word_a_s;
  logic [BIT_WIDTH-1:0] word_b_s;
  logic [BIT_WIDTH-1:0] word_sum_s;
  logic                 word_cout_s;

  assign idx_sel_s = idx_r[SEL_W-1:0];
  assign word_a_s  = op_a_r[idx_sel_s];
  assign word_b_s  = op_b_r[idx_sel_s];

  adder_nbit #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_adder_nbit (
    .a    (word_a_s),
    .b    (word_b_s),
    .cin  (carry_r),
    .sum  (word_sum_s),
    .cout (word_cout_s)
  );

  // Controller next-state and per-cycle strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = ADD;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADD: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          last_s       = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = ADD;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, word index, inter-word carry, result and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r     <= '0;
      op_b_r     <= '0;
      sum_r      <= '0;
      idx_r      <= ZERO_IDX;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      // Operands are latched here so the requester may change them freely
      // once the start has been taken.
      op_a_r  <= op_a;
      op_b_r  <= op_b;
      carry_r <= carry_in;
      sum_r   <= '0;
      idx_r   <= ZERO_IDX;
    end else if (step_s) begin
      sum_r[idx_sel_s] <= word_sum_s;
      carry_r          <= word_cout_s;
      if (last_s) begin
        // Index parks at 0 so it never reaches WORDS while in ADD.
        overflow_r <= word_cout_s;
        idx_r      <= ZERO_IDX;
      end else begin
        overflow_r <= overflow_r;
        idx_r      <= idx_r + ONE_IDX;
      end
    end else begin
      sum_r      <= sum_r;
      overflow_r <= overflow_r;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign overflow = overflow_r;

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Directed bench for adder_seq_ctrl: a 4x4-bit instance for the main cases and
// a 1x4-bit instance for the single-word case. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

  logic        clk;
  logic        rst;

  // 4-word instance
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        overflow;

  // 1-word instance
  logic        start1;
  logic [3:0]  op_a1;
  logic [3:0]  op_b1;
  logic        carry_in1;
  logic        busy1;
  logic        done1;
  logic [3:0]  sum1;
  logic        overflow1;

  int n_checks;
  int n_errors;

  adder_seq_ctrl #(
    .BIT_WIDTH (4),
    .WORDS     (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  adder_seq_ctrl #(
    .BIT_WIDTH (4),
    .WORDS     (1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .op_a     (op_a1),
    .op_b     (op_b1),
    .carry_in (carry_in1),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
    .overflow (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that accepted start (or later, see exp_lat).
  // Waits for done with a cycle budget and checks latency, busy length,
  // result and that done is a single-cycle pulse.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [15:0] exp_sum, input logic exp_ovf);
    int  busy_cnt = 0;
    int  lat      = 0;
    bit  seen     = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        step();
      end
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check_eq({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check_eq({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    step();
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_sum_hold"}, 64'(sum), 64'(exp_sum));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input logic [15:0] exp_sum, input logic exp_ovf);
    op_a     = a;
    op_b     = b;
    carry_in = ci;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(tag, 5, exp_sum, exp_ovf);
  endtask

  initial begin
    int cnt;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    op_a      = 16'h0000;
    op_b      = 16'h0000;
    carry_in  = 1'b0;
    start1    = 1'b0;
    op_a1     = 4'h0;
    op_b1     = 4'h0;
    carry_in1 = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_sum", 64'(sum), 64'd0);
    check_eq("reset_overflow", 64'(overflow), 64'd0);
    check_eq("reset_busy1", 64'(busy1), 64'd0);

    // Carry across word boundary, no overflow
    run_op("ff_plus_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    // Carry-in ripples through every word
    run_op("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    // Maximum operands
    run_op("max_max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Start held high for 8 edges: one op, then a second from the first
    // IDLE cycle after done.
    op_a     = 16'h1234;
    op_b     = 16'h1111;
    carry_in = 1'b0;
    start    = 1'b1;
    step();                                   // edge 1: accepted
    wait_done("held_first", 5, 16'h2345, 1'b0); // through edge 6
    check_eq("held_idle_gap", 64'(busy), 64'd0);
    op_b = 16'h0001;
    step();                                   // edge 7: accepted again
    check_eq("held_second_busy", 64'(busy), 64'd1);
    step();                                   // edge 8
    start = 1'b0;
    wait_done("held_second", 4, 16'h1235, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) cnt++;
      step();
    end
    check_eq("held_no_third_op", 64'(cnt), 64'd0);

    // Reset in the 2nd ADD cycle discards the operation
    op_a  = 16'hABCD;
    op_b  = 16'h1111;
    start = 1'b1;
    step();                 // accepted, 1st ADD cycle follows
    start = 1'b0;
    step();                 // now in 2nd ADD cycle
    check_eq("midrst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_sum", 64'(sum), 64'd0);
    check_eq("midrst_overflow", 64'(overflow), 64'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) cnt++;
    end
    check_eq("midrst_no_done", 64'(cnt), 64'd0);

    // Operand change after start must not affect the result
    op_a     = 16'h0001;
    op_b     = 16'h0001;
    carry_in = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    op_a  = 16'hFFFF;
    wait_done("captured_ops", 5, 16'h0002, 1'b0);

    // Single-word instance: 0xF + 0x1
    op_a1     = 4'hF;
    op_b1     = 4'h1;
    carry_in1 = 1'b0;
    start1    = 1'b1;
    step();
    start1 = 1'b0;
    check_eq("w1_busy_first", 64'(busy1), 64'd1);
    check_eq("w1_done_first", 64'(done1), 64'd0);
    step();
    check_eq("w1_done_second", 64'(done1), 64'd1);
    check_eq("w1_sum", 64'(sum1), 64'h0);
    check_eq("w1_overflow", 64'(overflow1), 64'd1);
    step();
    check_eq("w1_done_pulse", 64'(done1), 64'd0);
    check_eq("w1_busy_after", 64'(busy1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_adder_seq_ctrl
